fetch_queue_16: RTL and testbench

- Instruction fetch stage for the 16-bit single-cycle datapath; sits directly upstream of decode/register-file/ALU.
- Owns the PC and issues word reads to a synchronous instruction memory (1-cycle read latency).
- Buffers returned instructions, with their PCs, in a small FIFO and presents them to decode through a valid/ready handshake.
- Accepts a redirect (branch/jump target) that flushes all buffered and in-flight fetches.

---
 rtl/fetch_queue_16.sv | 114 +++++++++++
 tb/tb_fetch_queue_16.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_16.sv
// rtl/fetch_queue_16.sv - fetch stage: PC, imem requests, instruction FIFO, redirect flush
// Optional FETCH_PERF_EN adds the stall_cycles output.
module fetch_queue_16 #(
   parameter int          DEPTH    = 2,
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          IMEM_AW  = 10
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               fetch_en,
   input  logic               redirect_valid,
   input  logic [15:0]        redirect_pc,
   output logic               imem_en,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [15:0]        imem_rdata,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [15:0]        out_instr,
   output logic [15:0]        out_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]        stall_cycles
`endif
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

   typedef enum logic {IDLE, WAIT} infl_t;

   infl_t         infl_q;
   logic [15:0]   pc_q;
   logic [15:0]   infl_pc_q;
   logic [PW-1:0] rd_ptr_q;
   logic [PW-1:0] wr_ptr_q;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic [15:0]   instr_q [DEPTH];
   logic [15:0]   epc_q   [DEPTH];
   logic          pop;
   logic          push;
   logic [CW:0]   occupancy;

   assign pop  = out_valid && out_ready;
   assign push = (infl_q == WAIT) && !redirect_valid;

   // Credit counts the in-flight word so a response always has a free slot.
   assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, infl_q == WAIT} - {{CW{1'b0}}, pop};
   assign imem_en   = reset_n && fetch_en && !redirect_valid && (occupancy < DEPTH_C);
   assign imem_addr = pc_q[IMEM_AW:1];
   assign out_valid = (count_q != '0);
   assign out_instr = instr_q[rd_ptr_q];
   assign out_pc    = epc_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      if (push && !pop)
         count_d = count_q + 1'b1;
      else if (pop && !push)
         count_d = count_q - 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc_q      <= RESET_PC;
         infl_q    <= IDLE;
         infl_pc_q <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            instr_q[i] <= '0;
            epc_q[i]   <= '0;
         end
      end else if (redirect_valid) begin
         pc_q     <= redirect_pc & 16'hFFFE;
         infl_q   <= IDLE;
         count_q  <= '0;
         rd_ptr_q <= wr_ptr_q;
      end else begin
         if (imem_en) begin
            pc_q      <= pc_q + 16'd2;
            infl_pc_q <= pc_q;
            infl_q    <= WAIT;
         end else begin
            infl_q <= IDLE;
         end
         if (push) begin
            instr_q[wr_ptr_q] <= imem_rdata;
            epc_q[wr_ptr_q]   <= infl_pc_q;
            wr_ptr_q          <= wr_ptr_q + 1'b1;
         end
         if (pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

`ifdef FETCH_PERF_EN
   logic [15:0] stall_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         stall_q <= '0;
      else if (redirect_valid)
         stall_q <= '0;
      else if (out_ready && !out_valid && stall_q != 16'hFFFF)
         stall_q <= stall_q + 16'd1;
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fetch_queue_16.sv
// tb/tb_fetch_queue_16.sv - self-checking bench for fetch_queue_16
module tb_fetch_queue_16;
   logic        clock = 1'b0;
   logic        reset_n;
   logic        fetch_en;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        out_ready;
   logic        imem_en;
   logic [9:0]  imem_addr;
   logic [15:0] imem_rdata = 16'h0;
   logic        out_valid;
   logic [15:0] out_instr;
   logic [15:0] out_pc;
   logic        w_imem_en;
   logic [9:0]  w_imem_addr;
   logic [15:0] w_imem_rdata = 16'h0;
   logic        w_out_valid;
   logic [15:0] w_out_instr;
   logic [15:0] w_out_pc;
`ifdef FETCH_PERF_EN
   logic [15:0] stall_cycles;
   logic [15:0] w_stall_cycles;
`endif

   int total = 0;
   int bad   = 0;

   logic [15:0] m_pc;
   bit          m_infl;
   logic [15:0] m_infl_pc;
   logic [31:0] mq [$];

   always #5 clock = ~clock;

   fetch_queue_16 u_dut (
      .clock(clock), .reset_n(reset_n), .fetch_en(fetch_en),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc)
`ifdef FETCH_PERF_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   fetch_queue_16 #(.RESET_PC(16'hFFFC)) u_wrap (
      .clock(clock), .reset_n(reset_n), .fetch_en(fetch_en),
      .redirect_valid(1'b0), .redirect_pc(16'h0000),
      .imem_en(w_imem_en), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
      .out_valid(w_out_valid), .out_ready(1'b1),
      .out_instr(w_out_instr), .out_pc(w_out_pc)
`ifdef FETCH_PERF_EN
      , .stall_cycles(w_stall_cycles)
`endif
   );

   // Word n of instruction memory holds 16'hA000 + n.
   always @(posedge clock) begin
      if (imem_en)   imem_rdata   <= 16'hA000 + {6'b0, imem_addr};
      if (w_imem_en) w_imem_rdata <= 16'hA000 + {6'b0, w_imem_addr};
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reference model: PC, one in-flight tag and an ordered queue of (pc, instr).
   always @(negedge clock) begin
      bit e_en;
      bit e_pop;
      int occ;
      if (!reset_n) begin
         m_pc   = 16'h0000;
         m_infl = 1'b0;
         mq.delete();
         check("rst_out_valid", {31'b0, out_valid}, 32'd0);
         check("rst_imem_en", {31'b0, imem_en}, 32'd0);
         check("rst_out_pc", {16'b0, out_pc}, 32'd0);
         check("rst_out_instr", {16'b0, out_instr}, 32'd0);
      end else begin
         e_pop = (mq.size() != 0) && out_ready;
         occ   = mq.size() + (m_infl ? 1 : 0) - (e_pop ? 1 : 0);
         e_en  = fetch_en && !redirect_valid && (occ < 2);
         check("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
         check("imem_en", {31'b0, imem_en}, {31'b0, e_en});
         if (e_en)
            check("imem_addr", {22'b0, imem_addr}, {22'b0, m_pc[10:1]});
         if (mq.size() != 0) begin
            check("out_pc", {16'b0, out_pc}, {16'b0, mq[0][31:16]});
            check("out_instr", {16'b0, out_instr}, {16'b0, mq[0][15:0]});
         end
         if (redirect_valid) begin
            mq.delete();
            m_infl = 1'b0;
            m_pc   = {redirect_pc[15:1], 1'b0};
         end else begin
            if (e_pop)
               void'(mq.pop_front());
            if (m_infl)
               mq.push_back({m_infl_pc, 16'hA000 + {6'b0, m_infl_pc[10:1]}});
            m_infl = e_en;
            if (e_en) begin
               m_infl_pc = m_pc;
               m_pc      = m_pc + 16'd2;
            end
         end
      end
   end

   initial begin
      reset_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 16'h0;
      repeat (3) tick();

      // Streaming from reset, plus PC wrap on the second instance.
      reset_n = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
      #1;
      check("p1_first_en", {31'b0, imem_en}, 32'd1);
      check("p1_first_addr", {22'b0, imem_addr}, 32'h000);
      check("wrap_addr0", {22'b0, w_imem_addr}, 32'h3FE);
      tick();
      check("p1_c1_valid", {31'b0, out_valid}, 32'd0);
      check("wrap_addr1", {22'b0, w_imem_addr}, 32'h3FF);
      tick();
      check("p1_c2_valid", {31'b0, out_valid}, 32'd1);
      check("p1_c2_pc", {16'b0, out_pc}, 32'h0000);
      check("p1_c2_instr", {16'b0, out_instr}, 32'hA000);
      check("wrap_addr2", {22'b0, w_imem_addr}, 32'h000);
      check("wrap_pc0", {16'b0, w_out_pc}, 32'hFFFC);
      check("wrap_instr0", {16'b0, w_out_instr}, 32'hA3FE);
`ifdef FETCH_PERF_EN
      check("stall_first", {16'b0, stall_cycles}, 32'd2);
`endif
      tick();
      check("p1_c3_pc", {16'b0, out_pc}, 32'h0002);
      check("p1_c3_instr", {16'b0, out_instr}, 32'hA001);
      check("wrap_pc1", {16'b0, w_out_pc}, 32'hFFFE);
      tick();
      check("p1_c4_pc", {16'b0, out_pc}, 32'h0004);
      check("p1_c4_instr", {16'b0, out_instr}, 32'hA002);
      check("wrap_pc2", {16'b0, w_out_pc}, 32'h0000);
      tick();
      check("wrap_pc3", {16'b0, w_out_pc}, 32'h0002);

      // Back-pressure: queue fills, requests stop, head holds.
      reset_n = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1; out_ready = 1'b0;
      repeat (8) tick();
      check("full_imem_en", {31'b0, imem_en}, 32'd0);
      check("full_valid", {31'b0, out_valid}, 32'd1);
      check("full_pc", {16'b0, out_pc}, 32'h0000);
      check("full_instr", {16'b0, out_instr}, 32'hA000);
      out_ready = 1'b1;
      repeat (5) tick();

      // Redirect mid-stream with a word in flight.
      redirect_valid = 1'b1; redirect_pc = 16'h0041;
      #1;
      check("redir_T_en", {31'b0, imem_en}, 32'd0);
      tick();
      redirect_valid = 1'b0; redirect_pc = 16'h0;
      #1;
      check("redir_T1_valid", {31'b0, out_valid}, 32'd0);
      check("redir_T1_en", {31'b0, imem_en}, 32'd1);
      check("redir_T1_addr", {22'b0, imem_addr}, 32'h020);
`ifdef FETCH_PERF_EN
      check("stall_cleared", {16'b0, stall_cycles}, 32'd0);
`endif
      tick();
      check("redir_T2_valid", {31'b0, out_valid}, 32'd0);
      tick();
      check("redir_T3_valid", {31'b0, out_valid}, 32'd1);
      check("redir_T3_pc", {16'b0, out_pc}, 32'h0040);
      check("redir_T3_instr", {16'b0, out_instr}, 32'hA020);
      repeat (3) tick();

      // fetch_en low: queue drains and no new requests.
      fetch_en = 1'b0;
      repeat (4) tick();
      check("drain_valid", {31'b0, out_valid}, 32'd0);
      check("drain_en", {31'b0, imem_en}, 32'd0);
      fetch_en = 1'b1;
      repeat (3) tick();

      // Asynchronous reset with a request in flight.
      check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
      reset_n = 1'b0;
      #1;
      check("async_valid", {31'b0, out_valid}, 32'd0);
      check("async_en", {31'b0, imem_en}, 32'd0);
      repeat (2) tick();
      reset_n = 1'b1;
      #1;
      check("restart_en", {31'b0, imem_en}, 32'd1);
      check("restart_addr", {22'b0, imem_addr}, 32'h000);
      repeat (2) tick();
      check("restart_pc", {16'b0, out_pc}, 32'h0000);
      check("restart_instr", {16'b0, out_instr}, 32'hA000);
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
